// File: rtl/dmem_arbiter_rv32i_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// Handshake: a requester holds req plus its fields for the whole cycle. A gnt in that same
// cycle means the request was accepted. Exactly one response follows on the next cycle, as
// rvalid together with rdata and err. There is no back-pressure on responses.
interface dmem_arbiter_rv32i_if;
  logic        a_req;
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_unsigned;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        a_err;

  logic        b_req;
  logic        b_we;
  logic [1:0]  b_size;
  logic        b_unsigned;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_err;

  logic        mem_store;
  logic [1:0]  mem_storetype;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_size, a_unsigned, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata, a_err,
    input  b_req, b_we, b_size, b_unsigned, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata, b_err,
    output mem_store, mem_storetype, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_size, a_unsigned, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata, a_err,
    output b_req, b_we, b_size, b_unsigned, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata, b_err,
    input  mem_store, mem_storetype, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rv32i.sv
// Two-port RV32I data-memory arbiter: A (load/store unit) has priority, and B (debug/loader)
// is protected from starvation. It also aligns and extends loads and screens out misaligned accesses.
module dmem_arbiter_rv32i #(
  parameter  int STARVE_LIMIT = 4,
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  dmem_arbiter_rv32i_if.slave        bus,
  output logic [CW-1:0]              starve_cnt
);

  logic        a_gnt;
  logic        b_gnt;
  logic        any_gnt;
  logic        sel_we;
  logic        sel_unsigned;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] resp_data;

  // Grants are gated by reset_n so that nothing is accepted while reset is held, even between clock edges.
  always_comb begin
    b_gnt   = reset_n && bus.b_req &&
              (!bus.a_req || (starve_cnt == CW'(STARVE_LIMIT)));
    a_gnt   = reset_n && bus.a_req && !b_gnt;
    any_gnt = a_gnt || b_gnt;
  end

  assign bus.a_gnt = a_gnt;
  assign bus.b_gnt = b_gnt;

  always_comb begin
    if (b_gnt) begin
      sel_we       = bus.b_we;
      sel_unsigned = bus.b_unsigned;
      sel_size     = bus.b_size;
      sel_addr     = bus.b_addr;
      sel_wdata    = bus.b_wdata;
    end else begin
      sel_we       = bus.a_we;
      sel_unsigned = bus.a_unsigned;
      sel_size     = bus.a_size;
      sel_addr     = bus.a_addr;
      sel_wdata    = bus.a_wdata;
    end
  end

  always_comb begin
    case (sel_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = sel_addr[0];
      2'b10:   bad = |sel_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    mem_defaults();
    if (any_gnt) begin
      bus.mem_store     = sel_we && !bad;
      bus.mem_storetype = sel_size;
      bus.mem_addr      = sel_addr;
      bus.mem_wdata     = sel_wdata;
    end
  end

  function automatic void mem_defaults();
    bus.mem_store     = 1'b0;
    bus.mem_storetype = 2'b11;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
  endfunction

  // Lane selection and extension happen in the grant cycle, so that the response registers already hold the final value.
  always_comb begin
    lane_b = 8'(bus.mem_rdata >> {sel_addr[1:0], 3'b000});
    lane_h = sel_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (sel_size)
      2'b00:   load_data = {{24{~sel_unsigned & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{~sel_unsigned & lane_h[15]}}, lane_h};
      default: load_data = bus.mem_rdata;
    endcase
    resp_data = (sel_we || bad) ? '0 : load_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.a_rvalid <= 1'b0;
      bus.a_err    <= 1'b0;
      bus.a_rdata  <= '0;
      bus.b_rvalid <= 1'b0;
      bus.b_err    <= 1'b0;
      bus.b_rdata  <= '0;
      starve_cnt   <= '0;
    end else begin
      bus.a_rvalid <= a_gnt;
      bus.a_err    <= a_gnt && bad;
      bus.a_rdata  <= a_gnt ? resp_data : '0;
      bus.b_rvalid <= b_gnt;
      bus.b_err    <= b_gnt && bad;
      bus.b_rdata  <= b_gnt ? resp_data : '0;
      // Once reset is released, a pending b_req is always either granted or losing to A.
      if (b_gnt || !bus.b_req)
        starve_cnt <= '0;
      else if (a_gnt && (starve_cnt != CW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter_rv32i.sv
// Bench for dmem_arbiter_rv32i: a byte-lane memory environment, a behavioural reference model
// checked every cycle, and directed vectors with hand-computed results.
module tb_dmem_arbiter_rv32i;
  localparam int LIMIT = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] starve_cnt;
  int         checks = 0;
  int         errors = 0;

  dmem_arbiter_rv32i_if bus();

  dmem_arbiter_rv32i #(.STARVE_LIMIT(LIMIT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .starve_cnt (starve_cnt)
  );

  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b ^ 8'h5A, 8'h3C};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] st,
                                        input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    mask = (st == 2'd0) ? 32'hFF : (st == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = 8 * int'(off);
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] v;
    v = word >> (8 * int'(off));
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // ---------------- memory environment ----------------
  logic [31:0] env_mem [256];
  assign bus.mem_rdata = env_mem[bus.mem_addr[9:2]];

  always @(posedge clock)
    if (bus.mem_store)
      env_mem[bus.mem_addr[9:2]] <= merge(env_mem[bus.mem_addr[9:2]], bus.mem_storetype,
                                          bus.mem_addr[1:0], bus.mem_wdata);

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] ref_mem [256];
  int          waited = 0, n_waited = 0, b_wait_run = 0;
  logic        exp_a_rv = 0, exp_a_err = 0, exp_b_rv = 0, exp_b_err = 0;
  logic [31:0] exp_a_rd = 0, exp_b_rd = 0;
  logic        nxt_a_rv = 0, nxt_a_err = 0, nxt_b_rv = 0, nxt_b_err = 0;
  logic [31:0] nxt_a_rd = 0, nxt_b_rd = 0;

  always @(negedge clock) begin : model_cmp
    logic        eb, ea, we, uns, bad, g;
    logic [1:0]  sz;
    logic [31:0] ad, wd;
    int          idx;
    if (!reset_n) begin
      chk("rst_a_gnt", 32'(bus.a_gnt), 0);
      chk("rst_b_gnt", 32'(bus.b_gnt), 0);
      chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
      chk("rst_b_rvalid", 32'(bus.b_rvalid), 0);
      chk("rst_a_err", 32'(bus.a_err), 0);
      chk("rst_b_err", 32'(bus.b_err), 0);
      chk("rst_a_rdata", bus.a_rdata, 0);
      chk("rst_b_rdata", bus.b_rdata, 0);
      chk("rst_mem_store", 32'(bus.mem_store), 0);
      chk("rst_starve_cnt", 32'(starve_cnt), 0);
      {nxt_a_rv, nxt_a_err, nxt_b_rv, nxt_b_err} = '0;
      nxt_a_rd = 0; nxt_b_rd = 0; n_waited = 0; b_wait_run = 0;
    end else begin
      eb = bus.b_req && (!bus.a_req || waited == LIMIT);
      ea = bus.a_req && !eb;
      g  = ea || eb;
      if (eb) begin
        we = bus.b_we; uns = bus.b_unsigned; sz = bus.b_size; ad = bus.b_addr; wd = bus.b_wdata;
      end else begin
        we = bus.a_we; uns = bus.a_unsigned; sz = bus.a_size; ad = bus.a_addr; wd = bus.a_wdata;
      end
      bad = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
      chk("a_gnt", 32'(bus.a_gnt), 32'(ea));
      chk("b_gnt", 32'(bus.b_gnt), 32'(eb));
      chk("mem_store", 32'(bus.mem_store), 32'(g && we && !bad));
      chk("mem_storetype", 32'(bus.mem_storetype), g ? 32'(sz) : 32'd3);
      chk("mem_addr", bus.mem_addr, g ? ad : 32'd0);
      chk("mem_wdata", bus.mem_wdata, g ? wd : 32'd0);
      chk("starve_cnt", 32'(starve_cnt), 32'(waited));
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(exp_a_rv));
      if (exp_a_rv) begin
        chk("a_err", 32'(bus.a_err), 32'(exp_a_err));
        chk("a_rdata", bus.a_rdata, exp_a_rd);
      end
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(exp_b_rv));
      if (exp_b_rv) begin
        chk("b_err", 32'(bus.b_err), 32'(exp_b_err));
        chk("b_rdata", bus.b_rdata, exp_b_rd);
      end
      b_wait_run = (bus.b_req && !bus.b_gnt) ? b_wait_run + 1 : 0;
      chk("b_wait_bound", 32'(b_wait_run > LIMIT), 0);
      idx       = int'(ad[9:2]);
      nxt_a_rv  = ea;
      nxt_b_rv  = eb;
      nxt_a_err = ea && bad;
      nxt_b_err = eb && bad;
      nxt_a_rd  = (ea && !we && !bad) ? load_val(ref_mem[idx], sz, ad[1:0], uns) : 32'd0;
      nxt_b_rd  = (eb && !we && !bad) ? load_val(ref_mem[idx], sz, ad[1:0], uns) : 32'd0;
      if (g && we && !bad) ref_mem[idx] = merge(ref_mem[idx], sz, ad[1:0], wd);
      n_waited  = (bus.b_req && ea) ? ((waited < LIMIT) ? waited + 1 : LIMIT) : 0;
    end
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      {exp_a_rv, exp_a_err, exp_b_rv, exp_b_err} = '0;
      exp_a_rd = 0; exp_b_rd = 0; waited = 0;
    end else begin
      exp_a_rv = nxt_a_rv; exp_a_err = nxt_a_err; exp_a_rd = nxt_a_rd;
      exp_b_rv = nxt_b_rv; exp_b_err = nxt_b_err; exp_b_rd = nxt_b_rd;
      waited   = n_waited;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic port_b, input logic req, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (port_b) begin
      bus.b_req = req; bus.b_we = we; bus.b_size = size; bus.b_unsigned = uns;
      bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = req; bus.a_we = we; bus.a_size = size; bus.a_unsigned = uns;
      bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  task automatic idle_all();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        port_b;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_store;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[$];

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    reset_n = 1'b0;
    idle_all();
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    @(negedge clock);
    chk("lit_reset_blocks_gnt", 32'(bus.a_gnt), 0);
    chk("lit_reset_starve", 32'(starve_cnt), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle_all();
    next_cycle();

    // SW then LB signed from the top byte
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    next_cycle();
    idle_all();
    @(negedge clock);
    chk("lit_lb_rvalid", 32'(bus.a_rvalid), 1);
    chk("lit_lb_rdata", bus.a_rdata, 32'hFFFFFFDE);
    chk("lit_lb_err", 32'(bus.a_err), 0);
    next_cycle();

    // SH then back-to-back LHU / LH on the same word
    drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    @(negedge clock);
    chk("lit_lhu_rdata", bus.a_rdata, 32'h00008001);
    next_cycle();
    idle_all();
    @(negedge clock);
    chk("lit_lh_rdata", bus.a_rdata, 32'hFFFF8001);
    next_cycle();

    // Both ports requesting continuously: A,A,A,A,B repeating
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("lit_starve_b_gnt_%0d", i), 32'(bus.b_gnt), 32'((i % 5) == 4));
      chk($sformatf("lit_starve_a_gnt_%0d", i), 32'(bus.a_gnt), 32'((i % 5) != 4));
      next_cycle();
    end
    idle_all();
    next_cycle();

    // Alternating single-port traffic, lane extraction, misaligned and illegal accesses
    vt.push_back('{1'b1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000A5, 1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b0, 1'b0, 32'h000000A5});
    vt.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 1'b0, 1'b0, 32'hFFFFFFA5});
    vt.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 32'h23, 32'h00000080, 1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0, 1'b0, 32'hFFFF8034});
    vt.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h8034A578});
    vt.push_back('{1'b1, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0000A578});
    vt.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 1'b0, 1'b0, 32'h00000034});
    vt.push_back('{1'b1, 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 32'h01, 32'h0000BEEF, 1'b0, 1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b1, 2'd3, 1'b0, 32'h00, 32'h00000055, 1'b0, 1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 32'h03, 32'h00001234, 1'b0, 1'b1, 32'h0});
    vt.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h00FF5A3C});
    vt.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 32'h01, 32'h0, 1'b0, 1'b0, 32'h0000005A});
    vt.push_back('{1'b0, 1'b0, 2'd0, 1'b1, 32'h02, 32'h0, 1'b0, 1'b0, 32'h000000FF});
    vt.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 32'h02, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFF});
    vt.push_back('{1'b0, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0});
    vt.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D});
    for (int i = 0; i <= vt.size(); i++) begin
      idle_all();
      if (i < vt.size())
        drive(vt[i].port_b, 1'b1, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata);
      @(negedge clock);
      if (i < vt.size()) begin
        chk($sformatf("lit_vec%0d_gnt", i),
            32'(vt[i].port_b ? bus.b_gnt : bus.a_gnt), 1);
        chk($sformatf("lit_vec%0d_mem_store", i), 32'(bus.mem_store), 32'(vt[i].exp_store));
      end
      if (i > 0) begin
        chk($sformatf("lit_vec%0d_rvalid", i - 1),
            32'(vt[i-1].port_b ? bus.b_rvalid : bus.a_rvalid), 1);
        chk($sformatf("lit_vec%0d_err", i - 1),
            32'(vt[i-1].port_b ? bus.b_err : bus.a_err), 32'(vt[i-1].exp_err));
        chk($sformatf("lit_vec%0d_rdata", i - 1),
            vt[i-1].port_b ? bus.b_rdata : bus.a_rdata, vt[i-1].exp_rdata);
      end
      next_cycle();
    end

    // Idle bus
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("lit_idle_storetype", 32'(bus.mem_storetype), 32'd3);
      chk("lit_idle_rvalid", 32'(bus.a_rvalid | bus.b_rvalid), 0);
      next_cycle();
    end

    // Reset asserted while a load response is pending
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
    next_cycle();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("lit_async_a_gnt", 32'(bus.a_gnt), 0);
    chk("lit_async_a_rvalid", 32'(bus.a_rvalid), 0);
    chk("lit_async_a_rdata", bus.a_rdata, 0);
    chk("lit_async_starve", 32'(starve_cnt), 0);
    chk("lit_async_mem_storetype", 32'(bus.mem_storetype), 32'd3);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle_all();
    @(negedge clock);
    chk("lit_post_reset_a_rvalid", 32'(bus.a_rvalid), 0);
    chk("lit_post_reset_b_rvalid", 32'(bus.b_rvalid), 0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    @(negedge clock);
    chk("lit_first_grant", 32'(bus.a_gnt), 1);
    next_cycle();
    idle_all();
    @(negedge clock);
    chk("lit_first_resp", bus.a_rdata, 32'h8034A578);
    next_cycle();
    repeat (2) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter_rv32i.md
DMEM_ARBITER_RV32I -- requirements
Module: dmem_arbiter_rv32i

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive cycles port B waits while port A is granted.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports a_req/b_req, input, 1 each, request valid (A = core load/store unit, B = debug/loader).
REQ-005 SHALL have ports a_we/b_we, input, 1 each, 1 = store, 0 = load.
REQ-006 SHALL have ports a_size/b_size, input, 2 each: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-007 SHALL have ports a_unsigned/b_unsigned, input, 1 each, zero-extend load result when 1.
REQ-008 SHALL have ports a_addr/b_addr, input, 32 each, byte address.
REQ-009 SHALL have ports a_wdata/b_wdata, input, 32 each, store data, right-aligned.
REQ-010 SHALL have ports a_gnt/b_gnt, output, 1 each, combinational, request accepted this cycle.
REQ-011 SHALL have ports a_rvalid/b_rvalid, output, 1 each, registered, response valid.
REQ-012 SHALL have ports a_rdata/b_rdata, output, 32 each, registered, extended load data.
REQ-013 SHALL have ports a_err/b_err, output, 1 each, registered, qualified by rvalid.
REQ-014 SHALL have memory-side ports mem_store (out 1), mem_storetype (out 2, 00 SB/01 SH/10 SW), mem_addr (out 32), mem_wdata (out 32), mem_rdata (in 32, word at mem_addr[9:2], valid within grant cycle).

Function
REQ-015 SHALL grant at most one port per cycle; gnt asserted only when the matching req is 1.
REQ-016 SHALL grant A over B, except when starve_cnt equals STARVE_LIMIT and b_req=1, in which case B SHALL be granted.
REQ-017 SHALL keep a starve counter: increment (saturating at STARVE_LIMIT) on cycles with b_req=1 and a_gnt=1; clear on b_gnt or b_req=0.
REQ-018 SHALL drive mem_addr, mem_wdata, mem_storetype from the granted port combinationally in the grant cycle; with no grant, mem_store=0, mem_storetype=11, mem_addr=0, mem_wdata=0.
REQ-019 SHALL assert mem_store only for a granted, legal, aligned store.
REQ-020 SHALL treat as misaligned: size 01 with addr[0]=1; size 10 with addr[1:0]!=00; size 11 is illegal.
REQ-021 SHALL, for misaligned/illegal requests, still grant, issue no memory write, and return rvalid=1, err=1, rdata=0 next cycle.
REQ-022 SHALL return exactly one response per grant, rvalid high for one cycle, the cycle after the grant, on the granted port; stores return rdata=0, err=0.
REQ-023 SHALL capture mem_rdata at the rising edge ending the grant cycle and extract the lane selected by addr[1:0] (byte) or addr[1] (half) from the registered request.
REQ-024 SHALL sign-extend byte/half loads from bit 7/15 when unsigned=0; zero-extend when 1; words pass unchanged.
REQ-025 SHALL allow back-to-back grants every cycle on either port, including alternating A/B, with full throughput.
REQ-026 SHALL return a load issued the cycle after a store to the same word with the post-store data.

Reset
REQ-027 SHALL, while reset_n=0, force a_gnt=b_gnt=0, all rvalid/err=0, all rdata=0, starve_cnt=0, mem_store=0, regardless of clock.
REQ-028 SHALL discard any in-flight response when reset asserts mid-transaction; first grant possible in the first rising edge after reset_n deasserts.

Verification
REQ-029 A only: SW 0xDEADBEEF @0x10, then LB @0x13 signed -> cycle after load grant a_rvalid=1, a_rdata=0xFFFFFFDE, a_err=0.
REQ-030 LHU @0x12 after SH 0x8001 @0x12 -> a_rdata=0x00008001; LH same -> 0xFFFF8001.
REQ-031 a_req and b_req held high continuously, STARVE_LIMIT=4 -> grant pattern A,A,A,A,B repeating; B never waits more than 4 cycles.
REQ-032 B LW @0x06 -> b_gnt=1, mem_store=0, next cycle b_rvalid=1, b_err=1, b_rdata=0; SH @0x01 -> no write, err=1.
REQ-033 Load granted, reset_n pulsed low before next rising edge -> rvalid stays 0, all outputs at reset values, starve_cnt=0.
REQ-034 Idle (no req) -> mem_store=0, mem_storetype=11, no rvalid for any cycle.
